// File: rtl/sal_sched_pkg.sv
// Shared types and helpers for the SAL DDR command scheduler.
//   cmd_t   : DRAM command code issued by a bank controller (ACT/RD/WR/PRE).
//   CMD_W   : width of a command code.
//   is_cas  : true for column commands (RD/WR), which form the top-priority class.
package sal_sched_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    ACT = 2'd0,
    RD  = 2'd1,
    WR  = 2'd2,
    PRE = 2'd3
  } cmd_t;

  function automatic logic is_cas(input cmd_t c);
    return (c == RD) || (c == WR);
  endfunction

endpackage : sal_sched_pkg

// File: rtl/sal_rr_arb.sv
// Round-robin priority picker, purely combinational.
// Grants the first set bit of i_elig found when scanning upward from i_ptr,
// wrapping from N-1 back to 0.
//   i_elig  : eligible requester mask
//   i_ptr   : index with highest priority this cycle (must be < N)
//   o_grant : one-hot grant, all zero when i_elig is empty
module sal_rr_arb #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_elig,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  always_comb begin : pick
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    o_grant = '0;
    idx     = 0;
    // Walk from the farthest offset down to the nearest one; the last hit
    // overwrites earlier ones, so the nearest eligible requester wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(i_ptr) + k) % N;
      if (i_elig[idx]) begin
        o_grant      = '0;
        o_grant[idx] = 1'b1;
      end
    end
  end

endmodule : sal_rr_arb

// File: rtl/sal_cmd_sched.sv
// Command scheduler between the per-bank controllers and the DFI command path.
// Each cycle picks at most one ACT/RD/WR/PRE request, enforcing the inter-bank
// constraints tRRD, tCCD, tWTR and tRTW, and issues it one cycle later as a
// registered pulse.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid        : per-requester command pending
//   req_cmd          : per-requester command code, requester i at [2i+1:2i]
//   sched_block      : refresh/maintenance in progress, suppresses all grants
//   t_rrd/t_ccd/
//   t_wtr/t_rtw      : timing values in cycles (0 or 1 means unrestricted)
//   req_grant        : one-hot combinational grant, consumed this cycle
//   cmd_valid        : registered one-cycle command pulse
//   cmd_code/cmd_idx : registered code and requester index of that command
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int TW      = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  input  logic                     sched_block,
  input  logic [TW-1:0]            t_rrd,
  input  logic [TW-1:0]            t_ccd,
  input  logic [TW-1:0]            t_wtr,
  input  logic [TW-1:0]            t_rtw,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic                     cmd_valid,
  output logic [CMD_W-1:0]         cmd_code,
  output logic [IDX_W-1:0]         cmd_idx
);

  // A counter loaded with t-1 reaches zero exactly t cycles after the issue.
  function automatic logic [TW-1:0] load_val(input logic [TW-1:0] t);
    return (t > TW'(1)) ? t - 1'b1 : '0;
  endfunction

  logic [TW-1:0]      r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_cmd_valid;
  cmd_t               r_cmd_code;
  logic [IDX_W-1:0]   r_cmd_idx;

  cmd_t               w_cmd [NUM_REQ];
  logic [NUM_REQ-1:0] w_elig_cas, w_elig_act, w_elig_pre;
  logic [NUM_REQ-1:0] w_grant_cas, w_grant_act, w_grant_pre;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_win_idx;
  cmd_t               w_win_cmd;
  logic               w_any;

  // Per-requester eligibility, split into the three priority classes.
  always_comb begin
    w_elig_cas = '0;
    w_elig_act = '0;
    w_elig_pre = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cmd[i] = cmd_t'(req_cmd[i*CMD_W +: CMD_W]);
      if (req_valid[i] && !sched_block) begin
        if (is_cas(w_cmd[i])) begin
          // RD waits out write-to-read turnaround, WR waits out read-to-write.
          w_elig_cas[i] = (r_ccd_cnt == '0) &&
                          ((w_cmd[i] == RD) ? (r_wtr_cnt == '0) : (r_rtw_cnt == '0));
        end else if (w_cmd[i] == ACT) begin
          w_elig_act[i] = (r_rrd_cnt == '0);
        end else begin
          w_elig_pre[i] = 1'b1;
        end
      end
    end
  end

  // All classes share one pointer so fairness carries across command types.
  sal_rr_arb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb_cas (
    .i_elig(w_elig_cas), .i_ptr(r_rr_ptr), .o_grant(w_grant_cas)
  );
  sal_rr_arb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb_act (
    .i_elig(w_elig_act), .i_ptr(r_rr_ptr), .o_grant(w_grant_act)
  );
  sal_rr_arb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb_pre (
    .i_elig(w_elig_pre), .i_ptr(r_rr_ptr), .o_grant(w_grant_pre)
  );

  // Class mux (CAS > ACT > PRE) and one-hot to index/code decode.
  always_comb begin
    w_grant   = '0;
    w_win_idx = '0;
    w_win_cmd = ACT;
    // Counters are zero in reset, so the grant must be forced off explicitly.
    if (rst_n) begin
      if (|w_elig_cas)      w_grant = w_grant_cas;
      else if (|w_elig_act) w_grant = w_grant_act;
      else                  w_grant = w_grant_pre;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_idx = IDX_W'(i);
        w_win_cmd = w_cmd[i];
      end
    end
  end

  assign w_any     = |w_grant;
  assign req_grant = w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrd_cnt   <= '0;
      r_ccd_cnt   <= '0;
      r_wtr_cnt   <= '0;
      r_rtw_cnt   <= '0;
      r_rr_ptr    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= ACT;
      r_cmd_idx   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the later load below simply overrides the
      // decrement when both apply in the same cycle.
      r_rrd_cnt <= (r_rrd_cnt != '0) ? r_rrd_cnt - 1'b1 : '0;
      r_ccd_cnt <= (r_ccd_cnt != '0) ? r_ccd_cnt - 1'b1 : '0;
      r_wtr_cnt <= (r_wtr_cnt != '0) ? r_wtr_cnt - 1'b1 : '0;
      r_rtw_cnt <= (r_rtw_cnt != '0) ? r_rtw_cnt - 1'b1 : '0;
      r_cmd_valid <= w_any;
      if (w_any) begin
        case (w_win_cmd)
          ACT: r_rrd_cnt <= load_val(t_rrd);
          RD: begin
            r_ccd_cnt <= load_val(t_ccd);
            r_rtw_cnt <= load_val(t_rtw);
          end
          WR: begin
            r_ccd_cnt <= load_val(t_ccd);
            r_wtr_cnt <= load_val(t_wtr);
          end
          default: ;
        endcase
        r_rr_ptr   <= (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
        r_cmd_code <= w_win_cmd;
        r_cmd_idx  <= w_win_idx;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign cmd_idx   = r_cmd_idx;

endmodule : sal_cmd_sched

// File: tb/tb_sal_cmd_sched.sv
// Self-checking bench for sal_cmd_sched: directed scenarios with hand-derived
// expectations, plus randomized traffic against a cycle-stamp reference model.
module tb_sal_cmd_sched;
  import sal_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req_valid;
  logic [15:0] req_cmd;
  cmd_t        tb_cmd [8];
  logic        sched_block;
  logic [3:0]  t_rrd, t_ccd, t_wtr, t_rtw;
  logic [7:0]  req_grant;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic [2:0]  cmd_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_cmd = '0;
    for (int i = 0; i < 8; i++) req_cmd[i*2 +: 2] = tb_cmd[i];
  end

  sal_cmd_sched #(.NUM_REQ(8), .TW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
    .sched_block(sched_block), .t_rrd(t_rrd), .t_ccd(t_ccd), .t_wtr(t_wtr),
    .t_rtw(t_rtw), .req_grant(req_grant), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .cmd_idx(cmd_idx)
  );

  // ---------------- reference model ----------------
  // Each constraint is kept as "earliest cycle a command of this kind may issue".
  int   m_cyc, m_ptr, act_ok, ccd_ok, wtr_ok, rtw_ok;
  logic e_v;
  logic [1:0] e_code;
  logic [2:0] e_idx;

  task automatic model_reset();
    m_cyc = 0; m_ptr = 0; act_ok = 0; ccd_ok = 0; wtr_ok = 0; rtw_ok = 0;
    e_v = 1'b0; e_code = 2'd0; e_idx = 3'd0;
  endtask

  function automatic int class_of(cmd_t c);
    if (c == RD || c == WR) return 0;
    if (c == ACT) return 1;
    return 2;
  endfunction

  function automatic bit may_issue(cmd_t c);
    case (c)
      ACT:     return m_cyc >= act_ok;
      RD:      return (m_cyc >= ccd_ok) && (m_cyc >= wtr_ok);
      WR:      return (m_cyc >= ccd_ok) && (m_cyc >= rtw_ok);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] model_pick();
    logic [7:0] g;
    g = '0;
    if (!rst_n || sched_block) return g;
    for (int cls = 0; cls < 3; cls++) begin
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (m_ptr + k) % 8;
        if (req_valid[i] && class_of(tb_cmd[i]) == cls && may_issue(tb_cmd[i])) begin
          g[i] = 1'b1;
          return g;
        end
      end
    end
    return g;
  endfunction

  task automatic model_commit(input logic [7:0] g);
    e_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) begin
        case (tb_cmd[i])
          ACT: act_ok = m_cyc + int'(t_rrd);
          RD:  begin ccd_ok = m_cyc + int'(t_ccd); rtw_ok = m_cyc + int'(t_rtw); end
          WR:  begin ccd_ok = m_cyc + int'(t_ccd); wtr_ok = m_cyc + int'(t_wtr); end
          default: ;
        endcase
        e_v = 1'b1; e_code = tb_cmd[i]; e_idx = 3'(i);
        m_ptr = (i + 1) % 8;
      end
    end
    m_cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; sched_block = 1'b0;
    for (int i = 0; i < 8; i++) tb_cmd[i] = ACT;
    t_rrd = 4'd1; t_ccd = 4'd1; t_wtr = 4'd1; t_rtw = 4'd1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; sched_block = 1'b0; req_valid = 8'hFF;
    t_rrd = 4'd1; t_ccd = 4'd1; t_wtr = 4'd1; t_rtw = 4'd1;
    for (int i = 0; i < 8; i++) tb_cmd[i] = RD;
    @(negedge clk);
    n_tests++;
    if (req_grant !== 8'h00 || cmd_valid !== 1'b0 || cmd_idx !== 3'd0 || cmd_code !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%h valid=%b idx=%0d code=%0d, want 00/0/0/0",
               req_grant, cmd_valid, cmd_idx, cmd_code);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_grant !== 8'h01) begin
      n_fail++; $display("FAIL reset_first_grant: got %h want 01", req_grant);
    end
    @(negedge clk);
    n_tests++;
    if (cmd_valid !== 1'b1 || cmd_idx !== 3'd0 || req_grant !== 8'h02) begin
      n_fail++;
      $display("FAIL reset_first_cmd: valid=%b idx=%0d grant=%h, want 1/0/02",
               cmd_valid, cmd_idx, req_grant);
    end
    // Mid-traffic asynchronous reset: outputs clear without waiting for an edge.
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (req_grant !== 8'h00 || cmd_valid !== 1'b0 || cmd_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_async: grant=%h valid=%b idx=%0d, want 00/0/0",
               req_grant, cmd_valid, cmd_idx);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_grant !== 8'h01) begin
      n_fail++; $display("FAIL reset_regrant: got %h want 01", req_grant);
    end
    @(negedge clk);
    n_tests++;
    if (cmd_valid !== 1'b1 || cmd_idx !== 3'd0 || cmd_code !== 2'(RD)) begin
      n_fail++;
      $display("FAIL reset_regrant_cmd: valid=%b idx=%0d code=%0d, want 1/0/1",
               cmd_valid, cmd_idx, cmd_code);
    end
  endtask

  task automatic test_priority();
    logic [7:0] vin [5]   = '{8'h29, 8'h09, 8'h01, 8'h00, 8'h00};
    logic [7:0] exp_g [5] = '{8'h20, 8'h08, 8'h01, 8'h00, 8'h00};
    logic       exp_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_i [5] = '{3'd0, 3'd5, 3'd3, 3'd0, 3'd0};
    logic [1:0] exp_c [5] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd3};
    do_reset();
    tb_cmd[0] = PRE; tb_cmd[3] = ACT; tb_cmd[5] = RD;
    for (int k = 0; k < 5; k++) begin
      req_valid = vin[k];
      @(negedge clk);
      n_tests++;
      if (req_grant !== exp_g[k] || cmd_valid !== exp_v[k] ||
          cmd_idx !== exp_i[k] || cmd_code !== exp_c[k]) begin
        n_fail++;
        $display("FAIL priority[%0d]: grant=%h v=%b idx=%0d code=%0d, want %h/%b/%0d/%0d",
                 k, req_grant, cmd_valid, cmd_idx, cmd_code,
                 exp_g[k], exp_v[k], exp_i[k], exp_c[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) tb_cmd[i] = RD;
    req_valid = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] eg;
      eg = '0;
      eg[k % 8] = 1'b1;
      @(negedge clk);
      n_tests++;
      if (req_grant !== eg) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %h want %h", k, req_grant, eg);
      end
      if (k > 0) begin
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd_idx !== 3'((k - 1) % 8)) begin
          n_fail++;
          $display("FAIL rr_cmd_idx[%0d]: valid=%b idx=%0d want 1/%0d",
                   k, cmd_valid, cmd_idx, (k - 1) % 8);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rrd_ccd();
    logic [7:0] exp_a [4] = '{8'h02, 8'h00, 8'h00, 8'h04};
    logic [7:0] exp_b [9] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h40,
                              8'h00, 8'h00, 8'h00, 8'h10};
    do_reset();
    t_rrd = 4'd3;
    tb_cmd[1] = ACT; tb_cmd[2] = ACT;
    req_valid = 8'h06;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (req_grant !== exp_a[k]) begin
        n_fail++; $display("FAIL trrd[%0d]: got %h want %h", k, req_grant, exp_a[k]);
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~exp_a[k];
    end
    t_ccd = 4'd4;
    tb_cmd[4] = RD; tb_cmd[6] = RD;
    req_valid = 8'h50;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_tests++;
      if (req_grant !== exp_b[k]) begin
        n_fail++; $display("FAIL tccd[%0d]: got %h want %h", k, req_grant, exp_b[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_turnaround();
    logic [7:0] vin [9]   = '{8'h04, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h40, 8'h40, 8'h40};
    logic [7:0] exp_g [9] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h40};
    do_reset();
    t_wtr = 4'd5; t_rtw = 4'd3; t_ccd = 4'd2;
    tb_cmd[2] = WR; tb_cmd[1] = RD; tb_cmd[6] = WR;
    for (int k = 0; k < 9; k++) begin
      req_valid = vin[k];
      @(negedge clk);
      n_tests++;
      if (req_grant !== exp_g[k]) begin
        n_fail++; $display("FAIL turnaround[%0d]: got %h want %h", k, req_grant, exp_g[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_block();
    do_reset();
    t_rrd = 4'd8;
    tb_cmd[0] = ACT; tb_cmd[1] = ACT; tb_cmd[3] = PRE;
    for (int k = 0; k < 13; k++) begin
      logic [7:0] eg;
      sched_block = (k >= 1 && k <= 10);
      req_valid   = (k == 0) ? 8'h01 : (k == 12) ? 8'h08 : 8'h0A;
      eg          = (k == 0) ? 8'h01 : (k == 11) ? 8'h02 : (k == 12) ? 8'h08 : 8'h00;
      @(negedge clk);
      n_tests++;
      if (req_grant !== eg) begin
        n_fail++; $display("FAIL block_grant[%0d]: got %h want %h", k, req_grant, eg);
      end
      if (k == 1) begin
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd_idx !== 3'd0) begin
          n_fail++;
          $display("FAIL block_inflight: valid=%b idx=%0d want 1/0", cmd_valid, cmd_idx);
        end
      end
      @(posedge clk); #1;
    end
    sched_block = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int chunk = 0; chunk < 4; chunk++) begin
      t_rrd = 4'($urandom_range(0, 6)); t_ccd = 4'($urandom_range(0, 6));
      t_wtr = 4'($urandom_range(0, 6)); t_rtw = 4'($urandom_range(0, 6));
      for (int k = 0; k < 150; k++) begin
        logic [7:0] eg;
        req_valid   = 8'($urandom) & 8'($urandom | $urandom);
        sched_block = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < 8; i++) tb_cmd[i] = cmd_t'($urandom_range(0, 3));
        @(negedge clk);
        eg = model_pick();
        n_tests++;
        if (req_grant !== eg || cmd_valid !== e_v || cmd_idx !== e_idx || cmd_code !== e_code) begin
          n_fail++;
          $display("FAIL random[%0d.%0d]: grant=%h v=%b idx=%0d code=%0d, want %h/%b/%0d/%0d",
                   chunk, k, req_grant, cmd_valid, cmd_idx, cmd_code, eg, e_v, e_idx, e_code);
        end
        model_commit(eg);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_round_robin();
    test_rrd_ccd();
    test_turnaround();
    test_block();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sal_cmd_sched
